// File: rtl/fft_peak_ctrl.sv
// Post-FFT peak search: latches a 16-bin frame, then scans one bin per cycle through a
// shared squared-magnitude unit and reports the strongest bin with a done pulse.
module fft_peak_ctrl #(
  parameter bit SKIP_DC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic [31:0] peak_mag,
  output logic        busy,
  output logic        overrun
);

  // state | meaning
  // IDLE  | waiting for a frame
  // SCAN  | bin k of the banked frame goes through the magnitude unit this cycle
  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state, state_nxt;
  logic [31:0]  d_in [16];
  logic [31:0]  bank [16];
  logic [3:0]   k;
  logic [3:0]   best_idx;
  logic [31:0]  best_mag;
  logic         last, accept, drop;
  logic [31:0]  cur;
  logic signed [15:0] cur_re, cur_im;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]  mag_raw, mag;
  logic         take_new;
  logic [3:0]   cand_idx;
  logic [31:0]  cand_mag;

  assign d_in[0]  = fft_d0;
  assign d_in[1]  = fft_d1;
  assign d_in[2]  = fft_d2;
  assign d_in[3]  = fft_d3;
  assign d_in[4]  = fft_d4;
  assign d_in[5]  = fft_d5;
  assign d_in[6]  = fft_d6;
  assign d_in[7]  = fft_d7;
  assign d_in[8]  = fft_d8;
  assign d_in[9]  = fft_d9;
  assign d_in[10] = fft_d10;
  assign d_in[11] = fft_d11;
  assign d_in[12] = fft_d12;
  assign d_in[13] = fft_d13;
  assign d_in[14] = fft_d14;
  assign d_in[15] = fft_d15;

  // Accepting on the last scan cycle keeps the one-frame-per-16-cycles cadence gapless.
  assign last   = (state == SCAN) && (k == 4'd15);
  assign accept = fft_valid && ((state == IDLE) || last);
  assign drop   = fft_valid && (state == SCAN) && !last;

  assign cur    = bank[k];
  assign cur_re = cur[31:16];
  assign cur_im = cur[15:0];
  assign re_sq  = 32'(cur_re) * 32'(cur_re);
  assign im_sq  = 32'(cur_im) * 32'(cur_im);
  // Each square is at most 2^30, so the unsigned sum cannot overflow 32 bits.
  assign mag_raw = $unsigned(re_sq) + $unsigned(im_sq);
  assign mag     = (SKIP_DC && (k == 4'd0)) ? 32'd0 : mag_raw;

  assign take_new = (mag > best_mag);
  assign cand_idx = take_new ? k : best_idx;
  assign cand_mag = take_new ? mag : best_mag;

  assign busy = (state == SCAN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SCAN;
      SCAN: if (last)   state_nxt = accept ? SCAN : IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) bank <= d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= 4'd0;
      best_idx <= 4'd0;
      best_mag <= 32'd0;
      freq     <= 4'd0;
      peak_mag <= 32'd0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done    <= last;
      overrun <= drop;
      if (last) begin
        freq     <= cand_idx;
        peak_mag <= cand_mag;
      end
      if (accept) begin
        k        <= 4'd0;
        best_idx <= 4'd0;
        best_mag <= 32'd0;
      end else if (state == SCAN) begin
        k        <= k + 4'd1;
        best_idx <= cand_idx;
        best_mag <= cand_mag;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_ctrl.sv
// Directed bench for fft_peak_ctrl: two instances (DC skipped / DC searched) share stimulus.
module tb_fft_peak_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done, busy, overrun;
  logic [3:0]  freq;
  logic [31:0] peak_mag;
  logic        done0, busy0, overrun0;
  logic [3:0]  freq0;
  logic [31:0] peak_mag0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fft_peak_ctrl #(.SKIP_DC(1'b1)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag), .busy(busy), .overrun(overrun)
  );

  fft_peak_ctrl #(.SKIP_DC(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done0), .freq(freq0), .peak_mag(peak_mag0), .busy(busy0), .overrun(overrun0)
  );

  function automatic logic [31:0] pack(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) d[i] = 32'd0;
  endtask

  // Presents d for one cycle; returns in the k=0 scan cycle.
  task automatic send_frame();
    fft_valid = 1'b1;
    step();
    fft_valid = 1'b0;
  endtask

  // Cycle count is relative to the fft_valid cycle; 40 means done never came.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({done, busy, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {done, busy, overrun});
    end
    n_checks++;
    if (freq !== 4'd0 || peak_mag !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got freq=%0d mag=%0d want 0/0", freq, peak_mag);
    end
    n_checks++;
    if ({done0, busy0, overrun0, freq0} !== 7'd0 || peak_mag0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_dut0: got %b/%0d want all zero", {done0, busy0, overrun0, freq0}, peak_mag0);
    end
  endtask

  task automatic test_single_peak();
    int cyc;
    clear_frame();
    d[5] = pack(1000, 0);
    d[0] = pack(30000, 0);
    send_frame();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_scan: got %b want 1", busy);
    end
    d[5] = pack(7, 7);
    wait_done(cyc);
    n_checks++;
    if (cyc != 17) begin
      n_fail++; $display("FAIL single_latency: got %0d want 17", cyc);
    end
    n_checks++;
    if (freq !== 4'd5 || peak_mag !== 32'd1000000) begin
      n_fail++; $display("FAIL single_skipdc: got freq=%0d mag=%0d want 5/1000000", freq, peak_mag);
    end
    n_checks++;
    if (done0 !== 1'b1 || freq0 !== 4'd0 || peak_mag0 !== 32'd900000000) begin
      n_fail++; $display("FAIL single_withdc: got done=%b freq=%0d mag=%0d want 1/0/900000000", done0, freq0, peak_mag0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_done: got %b want 0", busy);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || freq !== 4'd5) begin
      n_fail++; $display("FAIL single_hold: got done=%b freq=%0d want 0/5", done, freq);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    int seen;
    clear_frame();
    d[9] = pack(0, 2000);
    send_frame();
    repeat (7) step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({done, busy, overrun} !== 3'b000 || freq !== 4'd0 || peak_mag !== 32'd0) begin
      n_fail++; $display("FAIL midscan_reset: got %b freq=%0d mag=%0d want all zero", {done, busy, overrun}, freq, peak_mag);
    end
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) seen++;
      step();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midscan_no_done: got %0d pulses want 0", seen);
    end
    clear_frame();
    d[11] = pack(-1500, 0);
    send_frame();
    wait_done(cyc);
    n_checks++;
    if (cyc != 17 || freq !== 4'd11 || peak_mag !== 32'd2250000) begin
      n_fail++; $display("FAIL midscan_next: got cyc=%0d freq=%0d mag=%0d want 17/11/2250000", cyc, freq, peak_mag);
    end
    step();
  endtask

  task automatic test_tie_sign();
    int cyc;
    clear_frame();
    d[3] = pack(-300, 400);
    d[9] = pack(500, 0);
    send_frame();
    wait_done(cyc);
    n_checks++;
    if (cyc != 17 || freq !== 4'd3 || peak_mag !== 32'd250000) begin
      n_fail++; $display("FAIL tie: got cyc=%0d freq=%0d mag=%0d want 17/3/250000", cyc, freq, peak_mag);
    end
    step();
    clear_frame();
    d[12] = pack(-32768, -32768);
    d[4]  = pack(32767, 32767);
    send_frame();
    wait_done(cyc);
    n_checks++;
    if (freq !== 4'd12 || peak_mag !== 32'h8000_0000) begin
      n_fail++; $display("FAIL extreme: got freq=%0d mag=%h want 12/80000000", freq, peak_mag);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int peaks [4];
    logic exp_done, exp_busy;
    logic [31:0] exp_mag;
    int f;
    int bad_done, bad_busy, bad_ovr, bad_res;
    peaks[0] = 1; peaks[1] = 2; peaks[2] = 15; peaks[3] = 8;
    bad_done = 0; bad_busy = 0; bad_ovr = 0; bad_res = 0;
    for (int t = 0; t <= 70; t++) begin
      if (t % 16 == 0 && t <= 48) begin
        clear_frame();
        f = t / 16;
        d[peaks[f]] = pack(1000 + 100 * f, 0);
        d[(peaks[f] + 3) % 16] = pack(0, 900);
        fft_valid = 1'b1;
      end else begin
        fft_valid = 1'b0;
      end
      exp_done = (t == 17 || t == 33 || t == 49 || t == 65);
      exp_busy = (t >= 1 && t <= 64);
      if (done !== exp_done) bad_done++;
      if (busy !== exp_busy) bad_busy++;
      if (overrun !== 1'b0) bad_ovr++;
      if (exp_done) begin
        f = (t - 17) / 16;
        exp_mag = 32'((1000 + 100 * f) * (1000 + 100 * f));
        n_checks++;
        if (freq !== 4'(peaks[f]) || peak_mag !== exp_mag) begin
          n_fail++; bad_res++;
          $display("FAIL b2b_result%0d: got freq=%0d mag=%0d want %0d/%0d", f, freq, peak_mag, peaks[f], exp_mag);
        end
      end
      step();
    end
    fft_valid = 1'b0;
    n_checks++;
    if (bad_done != 0) begin
      n_fail++; $display("FAIL b2b_done_timing: got %0d bad cycles want 0", bad_done);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++; $display("FAIL b2b_busy: got %0d bad cycles want 0", bad_busy);
    end
    n_checks++;
    if (bad_ovr != 0) begin
      n_fail++; $display("FAIL b2b_overrun: got %0d bad cycles want 0", bad_ovr);
    end
  endtask

  task automatic test_overrun();
    int n_done, bad_ovr;
    n_done = 0; bad_ovr = 0;
    for (int t = 0; t <= 40; t++) begin
      if (t == 0) begin
        clear_frame();
        d[7] = pack(1234, 0);
        fft_valid = 1'b1;
      end else if (t == 5) begin
        clear_frame();
        d[2] = pack(3000, 0);
        fft_valid = 1'b1;
      end else begin
        fft_valid = 1'b0;
        for (int i = 0; i < 16; i++) d[i] = $urandom;
      end
      if (overrun !== (t == 6)) bad_ovr++;
      if (done) begin
        n_done++;
        n_checks++;
        if (t != 17 || freq !== 4'd7 || peak_mag !== 32'd1522756) begin
          n_fail++; $display("FAIL ovr_result: got t=%0d freq=%0d mag=%0d want 17/7/1522756", t, freq, peak_mag);
        end
      end
      step();
    end
    fft_valid = 1'b0;
    n_checks++;
    if (bad_ovr != 0) begin
      n_fail++; $display("FAIL ovr_pulse: got %0d bad cycles want 0", bad_ovr);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL ovr_done_count: got %0d want 1", n_done);
    end
  endtask

  initial begin
    rst = 1'b0;
    fft_valid = 1'b0;
    clear_frame();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    step();
    test_single_peak();
    test_reset_mid_scan();
    test_tie_sign();
    test_back_to_back();
    step();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
